bus_step_controller: RTL
========================

// Module: bus_step_controller
// PURPOSE
//  Sequences 68000 bus cycles for the SPI debug monitor: free-run or single-step per monitor command.
//  Captures ADDR/DATA/RW of each cycle into snapshot registers feeding the monitor's send frame.
//  Withholds DTACK_N in step mode until the host issues a step.
//  Sits between the CPU bus, memory DTACK logic and the SPI monitor; monitor-side inputs are async.
// PARAMETERS
//  SYNC_STAGES  2   flop stages on each async input (SPISS_IN, CMD_IN)
//  RUN_WAIT     1   wait cycles in RUN mode between CAPTURE and ACK (0..15)
//  COUNT_W      16  width of completed-bus-cycle counter
// PORTS
//  CLK_IN         in   1        system clock (CPU clock domain)
//  RST_N_IN       in   1        async active-low reset
//  AS_N_IN        in   1        CPU address strobe, CLK_IN domain
//  RW_IN          in   1        CPU read/write (1=read)
//  ADDR_IN        in   24       CPU address bus
//  DATA_IN        in   16       CPU data bus
//  CMD_IN         in   4        monitor INPUT_SIGNAL, async: [0]=RUN, [1]=STEP toggle, [3:2] reserved
//  SPISS_IN       in   1        monitor slave select, async; 1 = frame shifting
//  DTACK_N        out  1        data acknowledge to CPU
//  SNAP_ADDR      out  24       snapshot address to monitor
//  SNAP_DATA      out  16       snapshot data to monitor
//  SNAP_SIGNAL    out  4        [0]=HELD, [1]=captured RW, [2]=RUN, [3]=AS active
//  CYCLE_COUNT    out  COUNT_W  completed bus cycles, wraps
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, DTACK_N=1, SNAP_*=0, CYCLE_COUNT=0, step token=0,
//   step-edge reference=0, wait counter=0, pending=0; synchronizer flops cleared.
//  CMD_IN and SPISS_IN pass SYNC_STAGES flops; all decisions use synchronized values only.
//  Step token: set when synced CMD[1] differs from stored reference (reference then updated);
//   several toggles before consumption collapse to one token; cleared when consumed in HOLD.
//  FSM:
//   IDLE:    DTACK_N=1; AS_N_IN==0 -> CAPTURE.
//   CAPTURE: 1 cycle; latch ADDR_IN, RW_IN; latch DATA_IN if RW_IN=0 (write).
//            RUN=1 -> WAIT (RUN_WAIT>0) or ACK (RUN_WAIT=0); RUN=0 -> HOLD.
//   WAIT:    count RUN_WAIT cycles -> ACK.
//   HOLD:    DTACK_N=1; token=1 or RUN=1 -> ACK (token cleared on this transition).
//   ACK:     DTACK_N=0 (registered, asserts 1 cycle after entry decision); for reads latch DATA_IN
//            on first ACK cycle; stay until AS_N_IN==1 -> IDLE, CYCLE_COUNT+1 (mod 2^COUNT_W).
//  Abort: AS_N_IN==1 in CAPTURE/WAIT/HOLD -> IDLE; no count, captured values not published,
//   token preserved.
//  Latency RUN mode: AS_N low at edge n -> DTACK_N low at edge n+2+RUN_WAIT.
//  Snapshot publish: captured ADDR/DATA/RW staged internally; copied to SNAP_* on entry to HOLD
//   and on ACK->IDLE, but only while synced SPISS_IN==0. If SPISS_IN==1, set pending and copy on
//   first cycle SPISS_IN==0; newer capture overwrites pending (latest wins). SNAP_* never change
//   while a frame shifts.
//  SNAP_SIGNAL[0],[2],[3] are live (state==HOLD, synced RUN, !AS_N_IN); [1] follows publish.
//  RUN rising while in HOLD releases the cycle; RUN falling mid-WAIT has no effect on that cycle.
//  Reserved CMD bits ignored.
// STRUCTURE
//  Package monitor_pkg: FSM state enum (IDLE,CAPTURE,WAIT,HOLD,ACK), CMD bit indices
//   (CMD_RUN=0, CMD_STEP=1), SNAP_SIGNAL bit indices, snapshot field widths (24/16/4).
//  Sub-module monitor_sync: parameterised width x SYNC_STAGES synchronizer, async active-low reset,
//   instanced once for {SPISS_IN, CMD_IN}.
// TESTING
//  1 RUN=1, RUN_WAIT=1, read at 24'h000400 data 16'h4E71 -> DTACK_N low 3 edges after AS_N falls;
//    SNAP_ADDR=000400, SNAP_DATA=4E71, SIGNAL[1]=1, CYCLE_COUNT=1 after AS_N rises.
//  2 RUN=0, write 16'hBEEF @ 24'h00FF00 -> HOLD, DTACK_N stays 1 for 100 cycles, SIGNAL[0]=1,
//    SNAP_ADDR=00FF00; one CMD[1] toggle -> DTACK_N low, count+1; next cycle holds again.
//  3 Three STEP toggles while IDLE -> exactly one cycle released, following cycle held.
//  4 SPISS_IN=1 across a completed cycle -> SNAP_* unchanged; on SPISS_IN=0 shows latest cycle
//    after SYNC_STAGES+1 edges.
//  5 AS_N deasserted while HOLD -> IDLE, count unchanged, token still 0; RST_N_IN pulled low in
//    ACK -> DTACK_N=1 immediately, all outputs 0.
//  6 CYCLE_COUNT preset path via 2^16 run-mode cycles -> wraps to 0.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types and constants for the 68000 bus step controller and its SPI monitor interface.
package monitor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      WAIT,
      HOLD,
      ACK
   } state_t;

   localparam int CMD_W    = 4;
   localparam int CMD_RUN  = 0;
   localparam int CMD_STEP = 1;

   localparam int SIG_HELD = 0;
   localparam int SIG_RW   = 1;
   localparam int SIG_RUN  = 2;
   localparam int SIG_AS   = 3;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam int SIG_W  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              rw;
   } snap_t;

endpackage

// File: rtl/bus_step_controller_if.sv
// CPU bus, monitor command and snapshot signals shared by the bus/monitor side and the step controller.
interface bus_step_controller_if
   import monitor_pkg::*;
#(
   parameter int COUNT_W = 16
);
   logic               AS_N_IN;
   logic               RW_IN;
   logic [ADDR_W-1:0]  ADDR_IN;
   logic [DATA_W-1:0]  DATA_IN;
   logic [CMD_W-1:0]   CMD_IN;
   logic               SPISS_IN;
   logic               DTACK_N;
   logic [ADDR_W-1:0]  SNAP_ADDR;
   logic [DATA_W-1:0]  SNAP_DATA;
   logic [SIG_W-1:0]   SNAP_SIGNAL;
   logic [COUNT_W-1:0] CYCLE_COUNT;

   modport master (
      output AS_N_IN, RW_IN, ADDR_IN, DATA_IN, CMD_IN, SPISS_IN,
      input  DTACK_N, SNAP_ADDR, SNAP_DATA, SNAP_SIGNAL, CYCLE_COUNT
   );

   modport slave (
      input  AS_N_IN, RW_IN, ADDR_IN, DATA_IN, CMD_IN, SPISS_IN,
      output DTACK_N, SNAP_ADDR, SNAP_DATA, SNAP_SIGNAL, CYCLE_COUNT
   );
endinterface

// File: rtl/monitor_sync.sv
// Multi-bit flop-chain synchronizer for the asynchronous monitor-side inputs.
module monitor_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             CLK_IN,
   input  logic             RST_N_IN,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   // NOTE: the chain is an array of real flops, not a RAM, so every element is reset
   // NOTE: and all sequential state uses <= so stage i reads the pre-edge value of stage i-1.
   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/bus_step_controller.sv
// Sequences 68000 bus cycles in free-run or single-step mode and publishes per-cycle snapshots to the SPI monitor.
module bus_step_controller
   import monitor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RUN_WAIT    = 1,
   parameter int COUNT_W     = 16
) (
   input logic                  CLK_IN,
   input logic                  RST_N_IN,
   bus_step_controller_if.slave bus
);

   logic [CMD_W:0]     sync_q;
   logic [1:0]         cmd_rsvd_unused;
   logic               spiss_s, run_s, step_s;

   state_t             state_q, state_d;
   logic [3:0]         wait_cnt_q;
   logic               dtack_n_q;
   logic               token_q, step_ref_q;
   logic [COUNT_W-1:0] cycle_cnt_q;
   snap_t              stage_q, stage_d, snap_q, pend_snap_q;
   logic               pend_q;
   logic               read_latch, complete, publish, consume;
   logic [SIG_W-1:0]   signal_d;

   monitor_sync #(.WIDTH(CMD_W + 1), .STAGES(SYNC_STAGES)) u_sync (
      .CLK_IN   (CLK_IN),
      .RST_N_IN (RST_N_IN),
      .d        ({bus.SPISS_IN, bus.CMD_IN}),
      .q        (sync_q)
   );

   assign spiss_s         = sync_q[CMD_W];
   assign run_s           = sync_q[CMD_RUN];
   assign step_s          = sync_q[CMD_STEP];
   assign cmd_rsvd_unused = sync_q[3:2];

   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // AS_N rising anywhere before ACK abandons the cycle without counting or publishing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!bus.AS_N_IN) state_d = CAPTURE;
         CAPTURE: begin
            if (bus.AS_N_IN)        state_d = IDLE;
            else if (!run_s)        state_d = HOLD;
            else if (RUN_WAIT > 0)  state_d = WAIT;
            else                    state_d = ACK;
         end
         WAIT: begin
            if (bus.AS_N_IN)                         state_d = IDLE;
            else if (wait_cnt_q == 4'(RUN_WAIT - 1)) state_d = ACK;
         end
         HOLD: begin
            if (bus.AS_N_IN)          state_d = IDLE;
            else if (token_q || run_s) state_d = ACK;
         end
         ACK:     if (bus.AS_N_IN) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      read_latch = (state_q == ACK) && dtack_n_q && stage_q.rw;
      complete   = (state_q == ACK) && (state_d == IDLE);
      publish    = ((state_q == CAPTURE) && (state_d == HOLD)) || complete;
      consume    = (state_q == HOLD) && (state_d == ACK);

      stage_d = stage_q;
      if (state_q == CAPTURE) begin
         stage_d.addr = bus.ADDR_IN;
         stage_d.rw   = bus.RW_IN;
         if (!bus.RW_IN) stage_d.data = bus.DATA_IN;
      end
      if (read_latch) stage_d.data = bus.DATA_IN;

      signal_d           = '0;
      signal_d[SIG_HELD] = (state_q == HOLD);
      signal_d[SIG_RW]   = snap_q.rw;
      signal_d[SIG_RUN]  = run_s;
      signal_d[SIG_AS]   = !bus.AS_N_IN;
   end

   // Publish uses stage_d so a capture and its publish can share one edge.
   always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
      if (!RST_N_IN) begin
         dtack_n_q   <= 1'b1;
         wait_cnt_q  <= '0;
         cycle_cnt_q <= '0;
         token_q     <= 1'b0;
         step_ref_q  <= 1'b0;
         stage_q     <= '0;
         snap_q      <= '0;
         pend_snap_q <= '0;
         pend_q      <= 1'b0;
      end else begin
         dtack_n_q  <= (state_q != ACK);
         wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
         stage_q    <= stage_d;
         if (complete) cycle_cnt_q <= cycle_cnt_q + COUNT_W'(1);

         if (step_s != step_ref_q) begin
            step_ref_q <= step_s;
            token_q    <= 1'b1;
         end else if (consume) begin
            token_q <= 1'b0;
         end

         if (publish && !spiss_s) begin
            snap_q <= stage_d;
            pend_q <= 1'b0;
         end else if (publish) begin
            pend_snap_q <= stage_d;
            pend_q      <= 1'b1;
         end else if (pend_q && !spiss_s) begin
            snap_q <= pend_snap_q;
            pend_q <= 1'b0;
         end
      end
   end

   assign bus.DTACK_N     = dtack_n_q;
   assign bus.SNAP_ADDR   = snap_q.addr;
   assign bus.SNAP_DATA   = snap_q.data;
   assign bus.SNAP_SIGNAL = signal_d;
   assign bus.CYCLE_COUNT = cycle_cnt_q;

endmodule
